// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared streaming FFT.
// Admits whole frames against output-FIFO credits and tags results with channel/last.
module fft_frame_arbiter #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DEPTH  = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   ch_valid,
  output logic [1:0]                   ch_ready,
  input  logic signed [DATA_WIDTH-1:0] ch0_real,
  input  logic signed [DATA_WIDTH-1:0] ch0_imag,
  input  logic signed [DATA_WIDTH-1:0] ch1_real,
  input  logic signed [DATA_WIDTH-1:0] ch1_imag,
  output logic                         fft_valid,
  output logic signed [DATA_WIDTH-1:0] fft_real,
  output logic signed [DATA_WIDTH-1:0] fft_imag,
  input  logic                         res_valid,
  input  logic                         out_rd,
  output logic                         res_ch,
  output logic                         res_last,
  output logic                         busy,
  output logic                         err_orphan
);

  localparam int CNT_W  = $clog2(N);
  localparam int CRD_W  = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TCNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_nxt;
  logic               last_grant;
  logic               chosen, start, beat, push, pop, tag_ne, orphan_hit;
  logic [CNT_W-1:0]   count, rcnt;
  logic [CRD_W-1:0]   credits, credits_nxt;
  logic               tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [TCNT_W-1:0]  tag_cnt;
  logic               vld_p1;
  logic signed [DATA_WIDTH-1:0] real_p1, imag_p1;

  always_comb begin
    state_nxt = state;
    chosen    = last_grant;
    start     = 1'b0;
    beat      = 1'b0;
    ch_ready  = 2'b00;
    case (state)
      IDLE: begin
        chosen = (ch_valid == 2'b11) ? ~last_grant : ch_valid[1];
        start  = (|ch_valid) && (credits >= CRD_W'(N)) && (tag_cnt != TCNT_W'(TAG_DEPTH));
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        ch_ready[last_grant] = 1'b1;
        beat = ch_valid[last_grant];
        if (beat && count == CNT_W'(N - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A start with a same-cycle out_rd nets -N+1; otherwise out_rd saturates at OUT_DEPTH.
  always_comb begin
    credits_nxt = credits;
    if (start)
      credits_nxt = credits - CRD_W'(N) + CRD_W'(out_rd);
    else if (out_rd && credits != CRD_W'(OUT_DEPTH))
      credits_nxt = credits + CRD_W'(1);
  end

  always_comb begin
    push       = start;
    tag_ne     = (tag_cnt != '0);
    pop        = res_valid && tag_ne && (rcnt == CNT_W'(N - 1));
    orphan_hit = res_valid && !tag_ne;
    res_ch     = tag_mem[rd_ptr];
    res_last   = res_valid && (rcnt == CNT_W'(N - 1));
    busy       = (state != IDLE) || tag_ne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
      credits    <= CRD_W'(OUT_DEPTH);
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_cnt    <= '0;
      rcnt       <= '0;
      err_orphan <= 1'b0;
    end else begin
      state   <= state_nxt;
      credits <= credits_nxt;
      if (start) begin
        last_grant <= chosen;
        count      <= '0;
      end else if (beat) begin
        count <= count + CNT_W'(1);
      end
      if (push) wr_ptr <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      tag_cnt <= tag_cnt + TCNT_W'(1);
      else if (pop && !push) tag_cnt <= tag_cnt - TCNT_W'(1);
      if (res_valid && tag_ne) rcnt <= pop ? '0 : rcnt + CNT_W'(1);
      if (orphan_hit) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= chosen;
  end

  // Stage p1: registered copy of the accepted beat into the FFT input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      real_p1 <= '0;
      imag_p1 <= '0;
    end else begin
      vld_p1 <= beat;
      if (beat) begin
        real_p1 <= last_grant ? ch1_real : ch0_real;
        imag_p1 <= last_grant ? ch1_imag : ch0_imag;
      end
    end
  end

  assign fft_valid = vld_p1;
  assign fft_real  = real_p1;
  assign fft_imag  = imag_p1;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed and randomized bench for fft_frame_arbiter against a queue-based
// frame/credit reference model; checks every output each cycle.
module tb_fft_frame_arbiter;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int OD = 32;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] ch_valid, ch_ready;
  logic signed [DW-1:0] ch0_real, ch0_imag, ch1_real, ch1_imag, fft_real, fft_imag;
  logic fft_valid, res_valid, out_rd, res_ch, res_last, busy, err_orphan;

  int checks = 0;
  int errors = 0;

  fft_frame_arbiter #(.N(N), .DATA_WIDTH(DW), .OUT_DEPTH(OD), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch0_real(ch0_real), .ch0_imag(ch0_imag), .ch1_real(ch1_real), .ch1_imag(ch1_imag),
    .fft_valid(fft_valid), .fft_real(fft_real), .fft_imag(fft_imag),
    .res_valid(res_valid), .out_rd(out_rd), .res_ch(res_ch), .res_last(res_last),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Reference model: frame in progress, owner, beats taken, credits, queue of frames in flight
  bit m_stream, m_last, m_orphan, m_fv, m_acc0, m_acc1;
  int m_cnt, m_credits, m_rcnt;
  int m_tags[$];
  logic signed [DW-1:0] m_fr, m_fi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stream = 0; m_last = 1; m_orphan = 0; m_fv = 0; m_acc0 = 0; m_acc1 = 0;
    m_cnt = 0; m_credits = OD; m_rcnt = 0; m_tags.delete(); m_fr = '0; m_fi = '0;
  endtask

  task automatic model_update();
    bit b, s, c;
    b = m_stream && ch_valid[m_last];
    s = !m_stream && ch_valid != 2'b00 && m_credits >= N && m_tags.size() < TD;
    c = (ch_valid == 2'b11) ? !m_last : ch_valid[1];
    m_acc0 = b && !m_last;
    m_acc1 = b && m_last;
    m_fv = b;
    if (b) begin
      m_fr = m_last ? ch1_real : ch0_real;
      m_fi = m_last ? ch1_imag : ch0_imag;
    end
    if (res_valid) begin
      if (m_tags.size() == 0) m_orphan = 1;
      else if (m_rcnt == N - 1) begin void'(m_tags.pop_front()); m_rcnt = 0; end
      else m_rcnt++;
    end
    if (b) begin
      if (m_cnt == N - 1) m_stream = 0; else m_cnt++;
    end
    if (s) begin
      m_stream = 1; m_last = c; m_cnt = 0; m_credits -= N; m_tags.push_back(int'(c));
    end
    if (out_rd && m_credits < OD) m_credits++;
  endtask

  task automatic check_all();
    logic [1:0] er;
    er = !m_stream ? 2'b00 : (m_last ? 2'b10 : 2'b01);
    chk("ch_ready", 32'(ch_ready), 32'(er));
    chk("fft_valid", 32'(fft_valid), 32'(m_fv));
    chk("fft_real", 32'(fft_real), 32'(m_fr));
    chk("fft_imag", 32'(fft_imag), 32'(m_fi));
    chk("busy", 32'(busy), 32'(m_stream || m_tags.size() != 0));
    chk("err_orphan", 32'(err_orphan), 32'(m_orphan));
    chk("res_last", 32'(res_last), 32'(res_valid && m_rcnt == N - 1));
    if (res_valid && m_tags.size() != 0) chk("res_ch", 32'(res_ch), 32'(m_tags[0]));
  endtask

  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; ch_valid = 0; res_valid = 0; out_rd = 0;
    #1;
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_fft_valid", 32'(fft_valid), 32'd0);
    chk("rst_fft_real", 32'(fft_real), 32'd0);
    chk("rst_fft_imag", 32'(fft_imag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    chk("rst_res_last", 32'(res_last), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_ch_ready", 32'(ch_ready), 32'd0);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int k, nfv, bad1, sum, rdy0;
    logic [1:0] prev;
    logic [1:0] grants[$];
    logic [1:0] exp_ord [4];
    int lasts[$];
    logic ch_b1, ch_b17;
    exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
    ch0_real = 0; ch0_imag = 0; ch1_real = 0; ch1_imag = 0;
    do_reset();

    // single channel, samples 1..16
    k = 1; nfv = 0; bad1 = 0; sum = 0;
    for (int i = 0; i < 20; i++) begin
      ch_valid = (k <= N) ? 2'b01 : 2'b00;
      ch0_real = 16'(k); ch0_imag = 16'(-k);
      tick();
      if (m_acc0) k++;
      if (fft_valid) begin nfv++; sum += int'(fft_real); end
      if (ch_ready[1]) bad1++;
    end
    chk("single_fft_beats", 32'(nfv), 32'd16);
    chk("single_sum", 32'(sum), 32'd136);
    chk("single_no_ch1", 32'(bad1), 32'd0);

    // second frame consumes remaining credit, third stalls
    rdy0 = 0; ch_valid = 2'b01;
    for (int i = 0; i < 40; i++) begin
      ch0_real = 16'($urandom); ch0_imag = 16'($urandom);
      tick();
      if (ch_ready[0]) rdy0++;
    end
    chk("stall_rdy_cycles", 32'(rdy0), 32'd16);
    chk("stall_no_start", 32'(ch_ready), 32'd0);
    out_rd = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("stall_15_credits", 32'(ch_ready), 32'd0);
    tick();
    tick();
    chk("start_with_out_rd", 32'(ch_ready), 32'b01);
    out_rd = 0;
    for (int i = 0; i < 36; i++) tick();
    out_rd = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("credit1_plus14", 32'(ch_ready), 32'd0);
    tick();
    out_rd = 0;
    tick();
    chk("credit1_plus15_start", 32'(ch_ready), 32'b01);
    do_reset();

    // contention: both channels, four frames
    ch_valid = 2'b11; out_rd = 1; prev = 0;
    for (int i = 0; i < 75; i++) begin
      ch0_real = 16'($urandom); ch0_imag = 16'($urandom);
      ch1_real = 16'($urandom); ch1_imag = 16'($urandom);
      tick();
      if (prev == 2'b00 && ch_ready != 2'b00) grants.push_back(ch_ready);
      prev = ch_ready;
    end
    chk("contention_frames", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("contention_order", 32'(grants[i]), 32'(exp_ord[i]));
    ch_valid = 0; out_rd = 0;

    // tagging of 64 results from the four frames
    ch_b1 = 1'bx; ch_b17 = 1'bx;
    for (int b = 1; b <= 64; b++) begin
      res_valid = 1;
      #1;
      if (res_last) lasts.push_back(b);
      if (b == 1) ch_b1 = res_ch;
      if (b == 17) ch_b17 = res_ch;
      tick();
    end
    res_valid = 0;
    chk("tag_res_ch_first", 32'(ch_b1), 32'd0);
    chk("tag_res_ch_second", 32'(ch_b17), 32'd1);
    chk("tag_last_count", 32'(lasts.size()), 32'd4);
    for (int i = 0; i < 4 && i < lasts.size(); i++) chk("tag_last_pos", 32'(lasts[i]), 32'(16 * (i + 1)));
    tick();
    chk("busy_after_drain", 32'(busy), 32'd0);

    // orphan result, sticky, then reset mid-frame
    res_valid = 1; tick(); res_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("orphan_sticky", 32'(err_orphan), 32'd1);
    ch_valid = 2'b10;
    for (int i = 0; i < 30 && !(m_stream && m_cnt == 7); i++) begin
      ch1_real = 16'($urandom); ch1_imag = 16'($urandom);
      tick();
    end
    chk("midframe_count7", 32'(m_cnt), 32'd7);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ch_valid = 2'($urandom_range(0, 3));
      out_rd = 1'($urandom % 2);
      res_valid = (m_tags.size() != 0) && ($urandom % 3 != 0);
      ch0_real = 16'($urandom); ch0_imag = 16'($urandom);
      ch1_real = 16'($urandom); ch1_imag = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
